tx_block_sr: RTL and testbench

Output serializer for the AES accelerator datapath. Accepts one full 128-bit cipher block from the AES core and emits it as consecutive 64-bit words toward the host-side transmit interface, most-significant word first. Mirrors the input shift register's byte ordering exactly, so a block collected and then re-emitted reproduces the original word stream. Provides valid/ready handshakes on both sides with zero-bubble back-to-back block streaming.

---
 rtl/aes_pkg.sv | 16 +
 rtl/flexbyte_pts_sr.sv | 35 +++
 rtl/tx_block_sr.sv | 76 +++++++
 tb/tb_tx_block_sr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES accelerator datapath.
// Holds the block and host-word sizes along with the transmit serializer state type.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int HOST_WORD_BYTES = 8;

    typedef logic [AES_BLOCK_BYTES*8-1:0] aes_block_t;
    typedef logic [HOST_WORD_BYTES*8-1:0] host_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/flexbyte_pts_sr.sv
// Parallel-to-serial byte shift register. The output word is always the most-significant
// NUM_BYTES_OUT bytes of the stored value. Each shift moves the value left by one output word.
module flexbyte_pts_sr
    import aes_pkg::*;
#(
    parameter int NUM_BYTES_IN  = AES_BLOCK_BYTES,
    parameter int NUM_BYTES_OUT = HOST_WORD_BYTES
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       load_enable,
    input  logic                       shift_enable,
    input  logic [NUM_BYTES_IN*8-1:0]  parallel_in,
    output logic [NUM_BYTES_OUT*8-1:0] serial_out
);

    localparam int IW = NUM_BYTES_IN * 8;
    localparam int OW = NUM_BYTES_OUT * 8;

    logic [IW-1:0] sr;

    // A load takes priority over a shift, so a new block can replace the last word in a single edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr <= '0;
        end else if (load_enable) begin
            sr <= parallel_in;
        end else if (shift_enable) begin
            sr <= {sr[IW-OW-1:0], {OW{1'b0}}};
        end
    end

    assign serial_out = sr[IW-1 -: OW];

endmodule

// File: rtl/tx_block_sr.sv
// Block-to-word transmit serializer. Emits the most-significant word first and uses
// valid/ready handshakes on both sides. The next block can be accepted on the edge that sends the last word.
module tx_block_sr
    import aes_pkg::*;
#(
    parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
    parameter int WORD_BYTES  = HOST_WORD_BYTES
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [BLOCK_BYTES*8-1:0] block_in,
    input  logic                     block_valid,
    output logic                     block_ready,
    output logic [WORD_BYTES*8-1:0]  data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     last_word,
    output logic                     busy
);

    localparam int NUM_WORDS = BLOCK_BYTES / WORD_BYTES;
    localparam int CW        = $clog2(NUM_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    tx_state_t     state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          xfer;
    logic          accept;

    assign busy        = (state == SEND);
    assign out_valid   = busy;
    assign last_word   = busy && (count == LAST_IDX);
    assign xfer        = out_valid && out_ready;
    assign block_ready = (state == IDLE) || (xfer && last_word);
    assign accept      = block_valid && block_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (accept) begin
            state_nxt = SEND;
            count_nxt = '0;
        end else if (xfer) begin
            if (last_word) begin
                state_nxt = IDLE;
                count_nxt = '0;
            end else begin
                count_nxt = count + CW'(1);
            end
        end
    end

    // A shift is skipped when a load occurs, because the load replaces the whole register.
    flexbyte_pts_sr #(
        .NUM_BYTES_IN  (BLOCK_BYTES),
        .NUM_BYTES_OUT (WORD_BYTES)
    ) u_pts_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_enable  (accept),
        .shift_enable (xfer && !accept),
        .parallel_in  (block_in),
        .serial_out   (data_out)
    );

endmodule

// File: tb/tb_tx_block_sr.sv
// Self-checking bench for tx_block_sr: a block-level reference model is compared every cycle,
// plus literal checks on hand-computed words and a loopback reassembly scoreboard.
module tb_tx_block_sr;

    localparam int BB = 16;
    localparam int WB = 8;
    localparam int NW = BB / WB;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [BB*8-1:0] block_in = '0;
    logic            block_valid = 1'b0;
    logic            block_ready;
    logic [WB*8-1:0] data_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            last_word;
    logic            busy;

    int tests = 0;
    int fails = 0;

    // Reference model: whether a block is held, the block itself, and the index of the next word to send.
    bit              m_held = 1'b0;
    logic [BB*8-1:0] m_blk = '0;
    int              m_k = 0;
    logic [BB*8-1:0] sent_q[$];
    logic [BB*8-1:0] rx_acc = '0;
    int              rx_blocks = 0;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    tx_block_sr dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .block_in    (block_in),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .last_word   (last_word),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WB*8-1:0] word_of(input logic [BB*8-1:0] b, input int k);
        return b[BB*8-1-k*WB*8 -: WB*8];
    endfunction

    // Compares on the falling edge, then advances the model and returns 1ns after the rising edge.
    task automatic cycle();
        bit exp_last, exp_ready;
        @(negedge clk);
        exp_last  = m_held && (m_k == NW-1);
        exp_ready = !m_held || (out_ready && exp_last);
        chk("out_valid", 128'(out_valid), 128'(m_held));
        chk("busy", 128'(busy), 128'(m_held));
        chk("last_word", 128'(last_word), 128'(exp_last));
        chk("block_ready", 128'(block_ready), 128'(exp_ready));
        if (m_held) chk("data_out", 128'(data_out), 128'(word_of(m_blk, m_k)));
        if (out_valid && out_ready) begin
            rx_acc = {rx_acc[BB*8-WB*8-1:0], data_out};
            if (last_word) begin
                if (sent_q.size() == 0) begin
                    chk("loopback_orphan", 128'(1), 128'(0));
                end else begin
                    chk("loopback_block", rx_acc, sent_q.pop_front());
                end
                rx_blocks++;
            end
        end
        if (n_rst) begin
            if (block_valid && exp_ready) begin
                m_held = 1'b1; m_blk = block_in; m_k = 0;
                sent_q.push_back(block_in);
            end else if (m_held && out_ready) begin
                if (m_k == NW-1) m_held = 1'b0;
                else m_k++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_k = 0; rx_acc = '0;
        sent_q.delete();
    endtask

    initial begin
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_data_out", 128'(data_out), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        #11 n_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_block_ready", 128'(block_ready), 128'(1));

        // A single block with out_ready held high.
        block_in = BLK_A; block_valid = 1'b1; out_ready = 1'b1;
        cycle();
        block_valid = 1'b0;
        chk("single_w0", 128'(data_out), 128'(64'h0011223344556677));
        chk("single_w0_last", 128'(last_word), 128'(0));
        cycle();
        chk("single_w1", 128'(data_out), 128'(64'h8899AABBCCDDEEFF));
        chk("single_w1_last", 128'(last_word), 128'(1));
        cycle();
        chk("single_done_valid", 128'(out_valid), 128'(0));
        chk("single_done_ready", 128'(block_ready), 128'(1));

        // Backpressure while word 0 is held. The offered block must be ignored.
        block_in = BLK_A; block_valid = 1'b1;
        cycle();
        block_in = BLK_B; out_ready = 1'b0;
        repeat (3) begin
            chk("stall_hold", 128'(data_out), 128'(64'h0011223344556677));
            chk("stall_ready", 128'(block_ready), 128'(0));
            cycle();
        end
        block_valid = 1'b0; out_ready = 1'b1;
        chk("stall_release_w0", 128'(data_out), 128'(64'h0011223344556677));
        cycle();
        chk("stall_resume_w1", 128'(data_out), 128'(64'h8899AABBCCDDEEFF));
        cycle();

        // Back-to-back blocks.
        block_in = BLK_A; block_valid = 1'b1;
        cycle();
        chk("b2b_a0", 128'(data_out), 128'(64'h0011223344556677));
        block_in = BLK_B;
        cycle();
        chk("b2b_a1", 128'(data_out), 128'(64'h8899AABBCCDDEEFF));
        chk("b2b_ready_on_last", 128'(block_ready), 128'(1));
        cycle();
        block_valid = 1'b0;
        chk("b2b_b0", 128'(data_out), 128'(64'hFEDCBA9876543210));
        chk("b2b_b0_valid", 128'(out_valid), 128'(1));
        cycle();
        chk("b2b_b1", 128'(data_out), 128'(64'h0F1E2D3C4B5A6978));
        cycle();

        // Reset after word 0 of a block has been transferred.
        block_in = BLK_A; block_valid = 1'b1;
        cycle();
        block_valid = 1'b0;
        cycle();
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_data", 128'(data_out), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        model_reset();
        cycle();
        cycle();
        n_rst = 1'b1;
        chk("midrst_ready", 128'(block_ready), 128'(1));
        block_in = BLK_B; block_valid = 1'b1;
        cycle();
        block_valid = 1'b0;
        chk("midrst_next_w0", 128'(data_out), 128'(64'hFEDCBA9876543210));
        cycle();
        cycle();

        // Random loopback: 100 blocks with random offers and stalls.
        rx_blocks = 0;
        for (int c = 0; c < 5000 && rx_blocks < 100; c++) begin
            block_in    = {$urandom, $urandom, $urandom, $urandom};
            block_valid = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            cycle();
        end
        chk("loopback_count", 128'(rx_blocks >= 100), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
